serial_mag_comp: RTL

Sequential N-bit unsigned magnitude comparator controller. Accepts an operand pair over a valid/ready handshake and time-multiplexes one 2-bit comparator slice across the operands, MSB pair first. Returns a one-hot equal/greater/less result over a second valid/ready handshake. Sits between operand producers and any consumer that needs wide compares without a wide combinational compare tree.

---
 rtl/serial_comp_pkg.sv | 18 +
 rtl/comp2_slice.sv | 22 ++
 rtl/serial_mag_comp.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/serial_comp_pkg.sv
// rtl/serial_comp_pkg.sv - shared FSM state type and width helpers for the serial comparator
package serial_comp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_ns(input int width);
    return width / 2;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 2) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/comp2_slice.sv
// rtl/comp2_slice.sv - combinational 2-bit unsigned comparator slice
module comp2_slice (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  logic [1:0] w_e;
  logic [1:0] w_g;
  logic [1:0] w_l;

  assign w_e = ~(a ^ b);
  assign w_g = a & ~b;
  assign w_l = ~a & b;

  assign gt = w_g[1] | (w_e[1] & w_g[0]);
  assign lt = w_l[1] | (w_e[1] & w_l[0]);
  assign eq = w_e[1] & w_e[0];

endmodule

// File: rtl/serial_mag_comp.sv
// rtl/serial_mag_comp.sv - serial MSB-first magnitude comparator; SERIAL_COMP_EARLY_EXIT_EN stops on first unequal slice
module serial_mag_comp
  import serial_comp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NS    = calc_ns(WIDTH);
  localparam int POS_W = (NS > 1) ? $clog2(NS) : 1;

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("serial_mag_comp: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [POS_W-1:0] r_pos;
  logic             r_decided;
  logic             r_gt;
  logic             r_lt;
  logic             r_eq_o;
  logic             r_gt_o;
  logic             r_lt_o;

  logic [1:0]       w_a_sl;
  logic [1:0]       w_b_sl;
  logic             w_sl_eq;
  logic             w_sl_gt;
  logic             w_sl_lt;
  logic             w_sl_neq;
  logic             w_last;
  logic             w_gt_fin;
  logic             w_lt_fin;

  assign w_a_sl = r_a[{r_pos, 1'b0} +: 2];
  assign w_b_sl = r_b[{r_pos, 1'b0} +: 2];

  comp2_slice u_slice (
    .a  (w_a_sl),
    .b  (w_b_sl),
    .eq (w_sl_eq),
    .gt (w_sl_gt),
    .lt (w_sl_lt)
  );

  assign w_sl_neq = ~w_sl_eq;

`ifdef SERIAL_COMP_EARLY_EXIT_EN
  assign w_last = (r_pos == '0) || w_sl_neq;
`else
  assign w_last = (r_pos == '0);
`endif

  // The first unequal slice wins; later slices only matter if nothing was decided yet.
  assign w_gt_fin = r_decided ? r_gt : w_sl_gt;
  assign w_lt_fin = r_decided ? r_lt : w_sl_lt;

  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign eq        = r_eq_o;
  assign gt        = r_gt_o;
  assign lt        = r_lt_o;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next_state = RUN;
      RUN:     if (w_last)    w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_eq_o    <= 1'b0;
      r_gt_o    <= 1'b0;
      r_lt_o    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a       <= a;
            r_b       <= b;
            r_pos     <= POS_W'(NS - 1);
            r_decided <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
          end
        end
        RUN: begin
          if (!r_decided && w_sl_neq) begin
            r_decided <= 1'b1;
            r_gt      <= w_sl_gt;
            r_lt      <= w_sl_lt;
          end
          if (w_last) begin
            r_gt_o <= w_gt_fin;
            r_lt_o <= w_lt_fin;
            r_eq_o <= ~(w_gt_fin | w_lt_fin);
          end else begin
            r_pos <= r_pos - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_eq_o <= 1'b0;
            r_gt_o <= 1'b0;
            r_lt_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
